// File: rtl/clk_monitor_pkg.sv
// clk_monitor_pkg: shared states, default rates and tolerance-bound helper for the enable monitor
package clk_monitor_pkg;
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam int SYS_CLK_HZ     = 58982000;
  localparam int TARGET_CE_HZ   = 22118400;
  localparam int DEFAULT_WINDOW = 58982;
  localparam int DEFAULT_EXPECT = 22118;
  function automatic longint bound(longint expect_cnt, longint tol, bit hi);
    return hi ? expect_cnt + tol : (expect_cnt > tol ? expect_cnt - tol : 0);
  endfunction
endpackage

// File: rtl/clk_enable_monitor_if.sv
// clk_enable_monitor_if: control inputs and measurement results of the enable-rate monitor
interface clk_enable_monitor_if #(parameter int CNT_W = 32);
  logic             ce_in;
  logic             start;
  logic             stop;
  logic             continuous;
  logic             busy;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             rate_ok;
  logic             too_fast;
  logic             too_slow;
  modport master (output ce_in, start, stop, continuous,
                  input busy, count_out, count_valid, rate_ok, too_fast, too_slow);
  modport slave  (input ce_in, start, stop, continuous,
                  output busy, count_out, count_valid, rate_ok, too_fast, too_slow);
endinterface

// File: rtl/ce_event_detect.sv
// ce_event_detect: turns ce_in into a one-cycle event, either level (strobe) or rising edge (toggle)
module ce_event_detect #(
  parameter int EDGE_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_i,
  output logic ev_o
);
  logic prev_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) prev_q <= 1'b0;
    else       prev_q <= ce_i;
  assign ev_o = (EDGE_MODE != 0) ? (ce_i & ~prev_q) : ce_i;
endmodule

// File: rtl/clk_enable_monitor.sv
// clk_enable_monitor: counts enable events over a fixed window and flags the rate against a tolerance band
module clk_enable_monitor import clk_monitor_pkg::*; #(
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW,
  parameter int EXPECT_COUNT  = DEFAULT_EXPECT,
  parameter int TOL           = 16,
  parameter int CNT_W         = 32,
  parameter int EDGE_MODE     = 0
) (
  input logic clk,
  input logic reset,
  clk_enable_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W:0]   LO     = (CNT_W+1)'(bound(EXPECT_COUNT, TOL, 1'b0));
  localparam logic [CNT_W:0]   HI     = (CNT_W+1)'(bound(EXPECT_COUNT, TOL, 1'b1));
  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d, ev_q, ev_d, rpt_q, rpt_d, cnt_q, cnt_d, ev_inc;
  logic             pend_q, pend_d, valid_q, valid_d, ok_q, ok_d, fast_q, fast_d, slow_q, slow_d;
  logic             ev;
  ce_event_detect #(.EDGE_MODE(EDGE_MODE)) u_det (
    .clk  (clk),
    .reset(reset),
    .ce_i (bus.ce_in),
    .ev_o (ev)
  );
  assign ev_inc = (&ev_q) ? ev_q : ev_q + CNT_W'(ev);
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ev_d    = ev_q;
    rpt_d   = rpt_q;
    pend_d  = 1'b0;
    valid_d = pend_q;
    cnt_d   = pend_q ? rpt_q : cnt_q;
    fast_d  = pend_q ? ((&rpt_q) | ({1'b0, rpt_q} > HI)) : fast_q;
    slow_d  = pend_q ? (~fast_d & ({1'b0, rpt_q} < LO)) : slow_q;
    ok_d    = pend_q ? (~fast_d & ~slow_d) : ok_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d = MEASURE;
      win_d   = RELOAD;
      ev_d    = '0;
    end else if (state_q == MEASURE) begin
      ev_d  = ev_inc;
      win_d = win_q - CNT_W'(1);
      if (win_q == '0) begin
        rpt_d   = ev_inc;
        pend_d  = 1'b1;
        win_d   = RELOAD;
        ev_d    = '0;
        state_d = bus.continuous ? MEASURE : IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      ev_q    <= '0;
      rpt_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
      fast_q  <= 1'b0;
      slow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ev_q    <= ev_d;
      rpt_q   <= rpt_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
      fast_q  <= fast_d;
      slow_q  <= slow_d;
    end
  assign bus.busy        = (state_q == MEASURE);
  assign bus.count_out   = cnt_q;
  assign bus.count_valid = valid_q;
  assign bus.rate_ok     = ok_q;
  assign bus.too_fast    = fast_q;
  assign bus.too_slow    = slow_q;
endmodule

// File: tb/tb_clk_enable_monitor.sv
// tb_clk_enable_monitor: directed stimulus with a per-instance report scoreboard (W=16, E=6, T=1)
module tb_clk_enable_monitor;
  typedef struct {
    int cnt;
    bit ok;
    bit fast;
    bit slow;
    int at;
  } exp_t;
  logic clk = 0, rst0 = 1, rst2 = 1;
  logic ce[3], st[3], sp[3], cont[3];
  int cyc = 0, checks = 0, fails = 0, c0;
  exp_t q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  clk_enable_monitor_if #(.CNT_W(8)) b0 ();
  clk_enable_monitor_if #(.CNT_W(8)) b1 ();
  clk_enable_monitor_if #(.CNT_W(4)) b2 ();
  assign b0.ce_in = ce[0];
  assign b0.start = st[0];
  assign b0.stop = sp[0];
  assign b0.continuous = cont[0];
  assign b1.ce_in = ce[1];
  assign b1.start = st[1];
  assign b1.stop = sp[1];
  assign b1.continuous = cont[1];
  assign b2.ce_in = ce[2];
  assign b2.start = st[2];
  assign b2.stop = sp[2];
  assign b2.continuous = cont[2];
  clk_enable_monitor #(.WINDOW_CYCLES(16), .EXPECT_COUNT(6), .TOL(1), .CNT_W(8), .EDGE_MODE(0))
    u0 (.clk(clk), .reset(rst0), .bus(b0));
  clk_enable_monitor #(.WINDOW_CYCLES(16), .EXPECT_COUNT(6), .TOL(1), .CNT_W(8), .EDGE_MODE(1))
    u1 (.clk(clk), .reset(rst0), .bus(b1));
  clk_enable_monitor #(.WINDOW_CYCLES(16), .EXPECT_COUNT(6), .TOL(1), .CNT_W(4), .EDGE_MODE(0))
    u2 (.clk(clk), .reset(rst2), .bus(b2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic compare(input string tag, input exp_t e, input logic [31:0] cnt,
                         input logic ok, input logic fast, input logic slow);
    chk({tag, " count_out"}, cnt, e.cnt);
    chk({tag, " rate_ok"}, {31'd0, ok}, {31'd0, e.ok});
    chk({tag, " too_fast"}, {31'd0, fast}, {31'd0, e.fast});
    chk({tag, " too_slow"}, {31'd0, slow}, {31'd0, e.slow});
    chk({tag, " report cycle"}, cyc, e.at);
  endtask
  always @(negedge clk) if (b0.count_valid) begin
    chk("u0 report expected", {31'd0, q0.size() != 0}, 1);
    if (q0.size() != 0) compare("u0", q0.pop_front(), b0.count_out, b0.rate_ok, b0.too_fast, b0.too_slow);
  end
  always @(negedge clk) if (b1.count_valid) begin
    chk("u1 report expected", {31'd0, q1.size() != 0}, 1);
    if (q1.size() != 0) compare("u1", q1.pop_front(), b1.count_out, b1.rate_ok, b1.too_fast, b1.too_slow);
  end
  always @(negedge clk) if (b2.count_valid) begin
    chk("u2 report expected", {31'd0, q2.size() != 0}, 1);
    if (q2.size() != 0) compare("u2", q2.pop_front(), b2.count_out, b2.rate_ok, b2.too_fast, b2.too_slow);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic pat(input int p, input int i);
    return p == 1 ? 1'b1 : p == 2 ? (i % 3 == 1) : p == 3 ? (i % 2 == 0) :
           p == 4 ? (((i - 1) / 2) % 2 == 1) : 1'b0;
  endfunction
  task automatic run(input int d, input int p, input int a, input int b);
    for (int i = a; i <= b; i++) begin
      ce[d] = pat(p, i);
      tick();
    end
  endtask
  task automatic arm(input int d, output int c);
    st[d] = 1;
    tick();
    st[d] = 0;
    c = cyc;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      ce[i] = 0;
      st[i] = 0;
      sp[i] = 0;
      cont[i] = 0;
    end
    repeat (2) tick();
    @(negedge clk);
    chk("reset busy", {31'd0, b0.busy}, 0);
    chk("reset count_out", {24'd0, b0.count_out}, 0);
    chk("reset count_valid", {31'd0, b0.count_valid}, 0);
    chk("reset rate_ok", {31'd0, b0.rate_ok}, 0);
    chk("reset too_fast", {31'd0, b0.too_fast}, 0);
    chk("reset too_slow", {31'd0, b0.too_slow}, 0);
    tick();
    rst0 = 0;
    rst2 = 0;
    repeat (2) tick();
    // strobe every third cycle: six events in E1..E16
    arm(0, c0);
    q0.push_back('{6, 1'b1, 1'b0, 1'b0, c0 + 17});
    chk("t1 busy while measuring", {31'd0, b0.busy}, 1);
    run(0, 2, 1, 16);
    @(negedge clk);
    chk("t1 busy low after E16", {31'd0, b0.busy}, 0);
    chk("t1 no valid at E16", {31'd0, b0.count_valid}, 0);
    repeat (3) tick();
    arm(0, c0);
    q0.push_back('{16, 1'b0, 1'b1, 1'b0, c0 + 17});
    run(0, 1, 1, 16);
    repeat (3) tick();
    arm(0, c0);
    q0.push_back('{0, 1'b0, 1'b0, 1'b1, c0 + 17});
    run(0, 0, 1, 16);
    repeat (3) tick();
    // edge mode: ce high across arming must not count as an edge
    ce[1] = 1;
    repeat (3) tick();
    arm(1, c0);
    q1.push_back('{4, 1'b0, 1'b0, 1'b1, c0 + 17});
    run(1, 4, 1, 16);
    repeat (3) tick();
    // continuous: three back-to-back windows, continuous dropped mid third window
    cont[0] = 1;
    arm(0, c0);
    for (int k = 0; k < 3; k++) q0.push_back('{8, 1'b0, 1'b1, 1'b0, c0 + 17 + 16 * k});
    run(0, 3, 1, 40);
    cont[0] = 0;
    run(0, 3, 41, 48);
    @(negedge clk);
    chk("t4 busy low after third window", {31'd0, b0.busy}, 0);
    repeat (3) tick();
    // stop at cycle 8 aborts with no report and holds prior outputs
    arm(0, c0);
    run(0, 1, 1, 7);
    sp[0] = 1;
    tick();
    sp[0] = 0;
    @(negedge clk);
    chk("t5 busy low after stop", {31'd0, b0.busy}, 0);
    repeat (20) tick();
    chk("t5 count_out held", {24'd0, b0.count_out}, 8);
    chk("t5 too_fast held", {31'd0, b0.too_fast}, 1);
    arm(0, c0);
    run(0, 1, 1, 7);
    arm(0, c0);
    q0.push_back('{16, 1'b0, 1'b1, 1'b0, c0 + 17});
    run(0, 1, 1, 16);
    repeat (3) tick();
    arm(0, c0);
    run(0, 0, 1, 15);
    arm(0, c0);
    q0.push_back('{16, 1'b0, 1'b1, 1'b0, c0 + 17});
    run(0, 1, 1, 16);
    repeat (3) tick();
    arm(0, c0);
    run(0, 1, 1, 4);
    st[0] = 1;
    sp[0] = 1;
    tick();
    st[0] = 0;
    sp[0] = 0;
    @(negedge clk);
    chk("t5 stop beats start", {31'd0, b0.busy}, 0);
    repeat (20) tick();
    // narrow counter saturates; async reset mid-window clears at once
    ce[2] = 1;
    arm(2, c0);
    q2.push_back('{15, 1'b0, 1'b1, 1'b0, c0 + 17});
    run(2, 1, 1, 16);
    repeat (3) tick();
    arm(2, c0);
    run(2, 1, 1, 8);
    rst2 = 1;
    #1;
    chk("t6 reset busy", {31'd0, b2.busy}, 0);
    chk("t6 reset count_out", {28'd0, b2.count_out}, 0);
    chk("t6 reset count_valid", {31'd0, b2.count_valid}, 0);
    chk("t6 reset rate_ok", {31'd0, b2.rate_ok}, 0);
    chk("t6 reset too_fast", {31'd0, b2.too_fast}, 0);
    chk("t6 reset too_slow", {31'd0, b2.too_slow}, 0);
    tick();
    rst2 = 0;
    repeat (20) tick();
    chk("u0 reports outstanding", q0.size(), 0);
    chk("u1 reports outstanding", q1.size(), 0);
    chk("u2 reports outstanding", q2.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
